// File: rtl/usart_arb_pkg.sv
// Shared types and constants for the USART transmit arbiter and its round-robin picker.
package usart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int unsigned DEFAULT_MAX_BURST    = 16;
    localparam int unsigned DEFAULT_IDLE_TIMEOUT = 32;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned grant_w(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/usart_rr_picker.sv
// Round-robin picker: first asserted request scanning ptr+1, ptr+2, ... modulo N.
module usart_rr_picker
    import usart_arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = grant_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] rr_ptr_i,
    output logic          found_o,
    output logic [IW-1:0] index_o
);

    logic [IW-1:0] cand [N];

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            cand[k] = IW'((32'(rr_ptr_i) + k + 32'd1) % N);
        end
    end

    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found_o && req_i[cand[k]]) begin
                found_o = 1'b1;
                index_o = cand[k];
            end
        end
    end

endmodule

// File: rtl/usart_tx_arbiter.sv
// Round-robin arbiter sharing one USART transmitter between NUM_REQ frame sources,
// with forced release on burst-length overrun or a stalled granted requester.
module usart_tx_arbiter
    import usart_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ      = 4,
    parameter  int unsigned DATA_LENGTH  = 8,
    parameter  int unsigned MAX_BURST    = DEFAULT_MAX_BURST,
    parameter  int unsigned IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT,
    localparam int unsigned GW           = grant_w(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_valid,
    output logic [DATA_LENGTH-1:0]         tx_data,
    input  logic                           tx_ready,
    output logic [GW-1:0]                  grant_id,
    output logic                           busy,
    output logic                           burst_overrun,
    output logic                           idle_timeout
);

    localparam int unsigned WCW = $clog2(MAX_BURST + 1);
    localparam int unsigned ICW = $clog2(IDLE_TIMEOUT + 1);

    arb_state_e       state_q, state_d;
    logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [WCW-1:0]   word_cnt_q, word_cnt_d;
    logic [ICW-1:0]   idle_cnt_q, idle_cnt_d;
    logic             busy_q, overrun_q, timeout_q;

    logic             pick_found;
    logic [GW-1:0]    pick_idx;
    logic             sel_valid, sel_last;
    logic [DATA_LENGTH-1:0] sel_data;
    logic             in_xfer, xfer_hs, burst_hit, idle_hit, frame_done;

    usart_rr_picker #(.N(NUM_REQ)) u_picker (
        .req_i    (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .found_o  (pick_found),
        .index_o  (pick_idx)
    );

    // Granted requester's lane.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == grant_q) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_LENGTH +: DATA_LENGTH];
            end
        end
    end

    assign in_xfer    = (state_q == XFER);
    assign xfer_hs    = in_xfer && sel_valid && tx_ready;
    assign frame_done = xfer_hs && sel_last;
    // A last word landing on the burst limit is a normal completion.
    assign burst_hit  = xfer_hs && !sel_last && (word_cnt_q == WCW'(MAX_BURST - 1));
    assign idle_hit   = in_xfer && !sel_valid && (idle_cnt_q == ICW'(IDLE_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_found) state_d = XFER;
            XFER:    if (frame_done || burst_hit || idle_hit) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (in_xfer) begin
            tx_valid = sel_valid;
            tx_data  = sel_data;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (GW'(i) == grant_q) req_ready[i] = tx_ready;
            end
        end
    end

    // Grant, pointer and counter bookkeeping.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        word_cnt_d = word_cnt_q;
        idle_cnt_d = idle_cnt_q;
        if (state_q == IDLE && pick_found) begin
            grant_d    = pick_idx;
            word_cnt_d = '0;
            idle_cnt_d = '0;
        end
        if (in_xfer) begin
            if (xfer_hs)        word_cnt_d = word_cnt_q + WCW'(1);
            if (sel_valid)      idle_cnt_d = '0;
            else if (!idle_hit) idle_cnt_d = idle_cnt_q + ICW'(1);
        end
        if (state_q == RELEASE) rr_ptr_d = grant_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= GW'(NUM_REQ - 1);
            grant_q    <= '0;
            word_cnt_q <= '0;
            idle_cnt_q <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            word_cnt_q <= word_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            busy_q     <= (state_d == XFER);
            overrun_q  <= burst_hit;
            timeout_q  <= idle_hit;
        end
    end

    assign grant_id      = grant_q;
    assign busy          = busy_q;
    assign burst_overrun = overrun_q;
    assign idle_timeout  = timeout_q;

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// Directed bench for usart_tx_arbiter: per-cycle check against a frame-level model plus literal checks.
module tb_usart_tx_arbiter;

    localparam int NR = 4;
    localparam int DL = 8;
    localparam int MB = 16;
    localparam int IT = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_last, req_ready;
    logic [NR*DL-1:0]  req_data;
    logic              tx_valid, tx_ready;
    logic [DL-1:0]     tx_data;
    logic [1:0]        grant_id;
    logic              busy, burst_overrun, idle_timeout;

    always #5 clk = ~clk;

    usart_tx_arbiter #(
        .NUM_REQ(NR), .DATA_LENGTH(DL), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .grant_id(grant_id), .busy(busy),
        .burst_overrun(burst_overrun), .idle_timeout(idle_timeout)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Per-requester word sources; gap = cycles valid stays low before presenting the word.
    logic [DL-1:0] sd [NR][64];
    logic          sl [NR][64];
    int            sg [NR][64];
    int            hd [NR];
    int            tl [NR];
    int            gapc [NR];
    bit            tog = 1'b0;

    // Handshake log and pulse counters.
    int lg_gid [256];
    int lg_dat [256];
    int lg_cyc [256];
    int lg_n = 0;
    int ovr_n = 0;
    int to_n = 0;
    int to_cyc = 0;

    // Frame-level model: owner (-1 none), dead cycles before next arbitration, last served.
    bit m_on = 1'b0;
    int m_owner, m_cool, m_ptr, m_gid, m_words, m_low;
    bit m_ovr, m_to;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            req_valid[r] = (hd[r] < tl[r]) && (gapc[r] == 0);
            req_data[r*DL +: DL] = (hd[r] < tl[r]) ? sd[r][hd[r]] : '0;
            req_last[r] = (hd[r] < tl[r]) ? sl[r][hd[r]] : 1'b0;
        end
    endtask

    task automatic flush();
        for (int r = 0; r < NR; r++) begin
            hd[r] = 0; tl[r] = 0; gapc[r] = 0;
        end
        drive();
    endtask

    task automatic push(input int r, input logic [DL-1:0] d, input logic l, input int g);
        if (hd[r] == tl[r]) gapc[r] = g;
        sd[r][tl[r]] = d;
        sl[r][tl[r]] = l;
        sg[r][tl[r]] = g;
        tl[r]++;
        drive();
    endtask

    task automatic end_frame();
        m_ptr   = m_owner;
        m_owner = -1;
        m_cool  = 1;
    endtask

    task automatic model_step();
        if (rst) begin
            m_on = 1'b1; m_owner = -1; m_cool = 0; m_ptr = NR - 1; m_gid = 0;
            m_words = 0; m_low = 0; m_ovr = 1'b0; m_to = 1'b0;
        end else if (m_on) begin
            m_ovr = 1'b0;
            m_to  = 1'b0;
            if (m_owner >= 0) begin
                if (req_valid[m_owner]) begin
                    m_low = 0;
                    if (tx_ready) begin
                        m_words++;
                        if (req_last[m_owner]) end_frame();
                        else if (m_words == MB) begin end_frame(); m_ovr = 1'b1; end
                    end
                end else begin
                    m_low++;
                    if (m_low == IT) begin end_frame(); m_to = 1'b1; end
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else begin
                for (int k = 1; k <= NR; k++) begin
                    if (m_owner < 0 && req_valid[(m_ptr + k) % NR]) begin
                        m_owner = (m_ptr + k) % NR;
                        m_gid = m_owner; m_words = 0; m_low = 0;
                    end
                end
            end
        end
    endtask

    // One clock: compare at negedge, advance model at posedge, then update sources.
    task automatic tick();
        logic [NR-1:0] hs, e_rdy;
        logic          e_vld;
        logic [DL-1:0] e_dat;
        @(negedge clk);
        hs = req_valid & req_ready;
        if (m_on) begin
            e_rdy = '0; e_vld = 1'b0; e_dat = '0;
            if (m_owner >= 0) begin
                e_vld = req_valid[m_owner];
                e_dat = req_data[m_owner*DL +: DL];
                e_rdy[m_owner] = tx_ready;
            end
            chk("busy",      32'(busy),          32'(m_owner >= 0));
            chk("tx_valid",  32'(tx_valid),      32'(e_vld));
            chk("tx_data",   32'(tx_data),       32'(e_dat));
            chk("req_ready", 32'(req_ready),     32'(e_rdy));
            chk("grant_id",  32'(grant_id),      32'(m_gid));
            chk("overrun",   32'(burst_overrun), 32'(m_ovr));
            chk("timeout",   32'(idle_timeout),  32'(m_to));
        end
        if (tx_valid && tx_ready && lg_n < 256) begin
            lg_gid[lg_n] = int'(grant_id);
            lg_dat[lg_n] = int'(tx_data);
            lg_cyc[lg_n] = cyc;
            lg_n++;
        end
        if (burst_overrun) ovr_n++;
        if (idle_timeout) begin to_n++; to_cyc = cyc; end
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        for (int r = 0; r < NR; r++) begin
            if (hs[r]) begin
                hd[r]++;
                gapc[r] = (hd[r] < tl[r]) ? sg[r][hd[r]] : 0;
            end else if (!req_valid[r] && gapc[r] > 0) begin
                gapc[r]--;
            end
        end
        if (tog) tx_ready = ~tx_ready;
        drive();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        flush();
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        int base, base2, o0, t0, w;
        int eg [9] = '{0, 1, 3, 0, 1, 3, 0, 1, 3};
        rst = 1'b1;
        tx_ready = 1'b0;
        flush();

        // Reset state, then single 3-word frame from requester 2.
        do_reset(2);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_valid",  32'(tx_valid), 32'd0);
        chk("rst_grant",  32'(grant_id), 32'd0);
        chk("rst_ready",  32'(req_ready), 32'd0);
        chk("rst_pulses", 32'({burst_overrun, idle_timeout}), 32'd0);
        tx_ready = 1'b1;
        base = lg_n; o0 = ovr_n; t0 = to_n;
        push(2, 8'hA1, 1'b0, 0);
        push(2, 8'hA2, 1'b0, 0);
        push(2, 8'hA3, 1'b1, 0);
        repeat (10) tick();
        chk("t1_count", 32'(lg_n - base), 32'd3);
        chk("t1_d0", 32'(lg_dat[base]),     32'hA1);
        chk("t1_d1", 32'(lg_dat[base + 1]), 32'hA2);
        chk("t1_d2", 32'(lg_dat[base + 2]), 32'hA3);
        chk("t1_gid", 32'(lg_gid[base + 2]), 32'd2);
        chk("t1_back2back", 32'(lg_cyc[base + 2] - lg_cyc[base]), 32'd2);
        chk("t1_pulses", 32'((ovr_n - o0) + (to_n - t0)), 32'd0);

        // Round robin over requesters 0,1,3 with 1-word frames.
        do_reset(1);
        tx_ready = 1'b1;
        base = lg_n;
        for (int rep = 0; rep < 3; rep++) begin
            push(0, 8'(rep),      1'b1, 0);
            push(1, 8'(16 + rep), 1'b1, 0);
            push(3, 8'(48 + rep), 1'b1, 0);
        end
        repeat (40) tick();
        chk("t2_count", 32'(lg_n - base), 32'd9);
        for (int i = 0; i < 9; i++) begin
            chk("t2_gid",  32'(lg_gid[base + i]), 32'(eg[i]));
            chk("t2_data", 32'(lg_dat[base + i]), 32'(16 * eg[i] + i / 3));
            if (i > 0) chk("t2_gap", 32'(lg_cyc[base + i] - lg_cyc[base + i - 1]), 32'd3);
        end

        // Burst overrun: requester 1 streams 20 words without last.
        do_reset(1);
        tx_ready = 1'b1;
        base = lg_n; o0 = ovr_n;
        for (int k = 0; k < 20; k++) push(1, 8'(8'h30 + k), 1'b0, 0);
        tick(); tick();
        push(0, 8'h40, 1'b1, 0);
        push(3, 8'h43, 1'b1, 0);
        repeat (90) tick();
        for (int k = 0; k < 16; k++) begin
            chk("t3_gid",  32'(lg_gid[base + k]), 32'd1);
            chk("t3_data", 32'(lg_dat[base + k]), 32'(8'h30 + k));
        end
        chk("t3_after_a", 32'(lg_gid[base + 16]), 32'd3);
        chk("t3_after_b", 32'(lg_gid[base + 17]), 32'd0);
        chk("t3_regrant", 32'(lg_gid[base + 18]), 32'd1);
        chk("t3_resume",  32'(lg_dat[base + 18]), 32'h40);
        chk("t3_ovr_once", 32'(ovr_n - o0), 32'd1);

        // Idle timeout: requester 0 stalls 40 cycles after its first word.
        do_reset(1);
        tx_ready = 1'b1;
        base = lg_n; t0 = to_n;
        push(0, 8'h60, 1'b0, 0);
        push(0, 8'h61, 1'b1, 40);
        push(3, 8'h63, 1'b1, 0);
        repeat (60) tick();
        chk("t4_first",   32'(lg_dat[base]), 32'h60);
        chk("t4_to_once", 32'(to_n - t0), 32'd1);
        chk("t4_to_cyc",  32'(to_cyc - lg_cyc[base]), 32'd33);
        chk("t4_next",    32'(lg_gid[base + 1]), 32'd3);
        chk("t4_next_cyc", 32'(lg_cyc[base + 1] - lg_cyc[base]), 32'd35);
        chk("t4_late",    32'(lg_dat[base + 2]), 32'h61);

        // Toggling tx_ready during a 4-word frame from requester 2.
        do_reset(1);
        tx_ready = 1'b1;
        base = lg_n;
        for (int k = 0; k < 4; k++) push(2, 8'(8'hB0 + k), 1'(k == 3), 0);
        tog = 1'b1;
        repeat (16) tick();
        tog = 1'b0;
        tx_ready = 1'b1;
        chk("t5_count", 32'(lg_n - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t5_data", 32'(lg_dat[base + k]), 32'(8'hB0 + k));
            if (k > 0) chk("t5_spacing", 32'(lg_cyc[base + k] - lg_cyc[base + k - 1]), 32'd2);
        end

        // Reset after word 2 of a 5-word frame; pointer must restart at requester 0.
        do_reset(1);
        tx_ready = 1'b1;
        base = lg_n;
        push(0, 8'h7F, 1'b1, 0);
        for (int k = 0; k < 5; k++) push(1, 8'(8'h70 + k), 1'(k == 4), 0);
        w = 0;
        while (lg_n < base + 3 && w < 30) begin tick(); w++; end
        chk("t6_wait", 32'(lg_n >= base + 3), 32'd1);
        rst = 1'b1;
        tx_ready = 1'b0;
        push(0, 8'h80, 1'b1, 0);
        tick();
        rst = 1'b0;
        tx_ready = 1'b1;
        chk("t6_valid", 32'(tx_valid), 32'd0);
        chk("t6_busy",  32'(busy), 32'd0);
        chk("t6_grant", 32'(grant_id), 32'd0);
        chk("t6_nomore", 32'(lg_n - base), 32'd3);
        base2 = lg_n;
        repeat (20) tick();
        chk("t6_first_gid",  32'(lg_gid[base2]), 32'd0);
        chk("t6_first_data", 32'(lg_dat[base2]), 32'h80);
        chk("t6_second_gid", 32'(lg_gid[base2 + 1]), 32'd1);
        chk("t6_second_dat", 32'(lg_dat[base2 + 1]), 32'h72);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usart_tx_arbiter.md
Name: usart_tx_arbiter

Overview:
- Shares the single USART transmitter between NUM_REQ independent frame sources, e.g. the DAQ sample packer, status reporter and command-echo path.
- Grants one requester at a time in round-robin order and holds the grant for a whole frame (burst of words up to req_last).
- Forwards words over a valid/ready handshake to the transmitter.
- Enforces a maximum burst length and an idle timeout so a stalled requester cannot lock the link.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_LENGTH, 8, word width; equals USART_DATA_LENGTH.
- MAX_BURST, 16, maximum words per grant before forced release.
- IDLE_TIMEOUT, 32, cycles the granted requester may hold valid low mid-burst before forced release.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*DATA_LENGTH  packed words; requester i occupies bits [i*DATA_LENGTH +: DATA_LENGTH].
- req_last  in  NUM_REQ  marks the final word of a frame.
- req_ready  out  NUM_REQ  per-requester accept.
- tx_valid  out  1  word valid to the transmitter.
- tx_data  out  DATA_LENGTH  word to the transmitter.
- tx_ready  in  1  transmitter accepts the word.
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester.
- busy  out  1  high while a grant is held.
- burst_overrun  out  1  one-cycle pulse on a MAX_BURST forced release.
- idle_timeout  out  1  one-cycle pulse on an IDLE_TIMEOUT forced release.

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=NUM_REQ-1, so requester 0 wins first.
  - grant_id=0, word_cnt=0, idle_cnt=0.
  - All outputs 0.
- Reset mid-burst aborts the frame immediately. No further tx_valid is issued. The transmitter sees nothing beyond words already handshaked.
- State machine:
  - IDLE: if any req_valid, pick the first asserted index scanning rr_ptr+1, rr_ptr+2, … modulo NUM_REQ. Register grant_id, clear both counters, go to XFER. With no request, stay in IDLE.
  - XFER:
    - busy=1.
    - tx_valid = req_valid[grant_id]; tx_data = req_data slice[grant_id] (combinational mux).
    - req_ready[grant_id] = tx_ready; all other req_ready=0.
    - Transfer occurs when tx_valid && tx_ready; each transfer increments word_cnt.
    - Transfer with req_last[grant_id] → RELEASE.
    - Transfer taking word_cnt to MAX_BURST without last → RELEASE, burst_overrun=1 in the following cycle.
    - While req_valid[grant_id]=0, idle_cnt increments; any valid cycle clears it.
    - idle_cnt reaching IDLE_TIMEOUT-1 with valid still low → RELEASE, idle_timeout=1 in the following cycle.
  - RELEASE (1 cycle): busy=0, rr_ptr<=grant_id, then IDLE.
- Latency:
  - Request asserted at cycle N in IDLE → tx_valid earliest N+1.
  - Frame end at cycle M → next grant decided at M+2 and its first word can be presented at M+3.
  - Minimum arbitration gap between frames is 2 cycles.
- Simultaneous events:
  - Last word coincident with word_cnt reaching MAX_BURST counts as normal completion; no overrun pulse.
  - A transfer in the same cycle the idle timeout would fire is impossible, because the timeout requires valid low.
- Requester holding valid while not granted sees req_ready=0. It must hold data stable (AXI-style); the arbiter never drops a presented word.
- A single requester with continuous back-to-back frames still yields the 2-cycle gap between its frames. When it is the only requester, it is re-granted.
- Counters: word_cnt width $clog2(MAX_BURST+1), idle_cnt width $clog2(IDLE_TIMEOUT+1); neither wraps.
- grant_id holds its value after RELEASE until the next grant.

Decomposition:
- Package usart_arb_pkg holds:
  - the state enum (IDLE, XFER, RELEASE);
  - the default MAX_BURST and IDLE_TIMEOUT constants;
  - a function returning the grant-index width.
- One combinational sub-module, usart_rr_picker: inputs req vector and rr_ptr; outputs found and index. It is reused by the planned RX command dispatcher.

Test Plan:
- Single requester 2 sends 3-word frame 0xA1,0xA2,0xA3 (last on 3rd), tx_ready=1 → tx_data sequence A1,A2,A3 on consecutive cycles, grant_id=2, busy falls after 3rd word, no error pulses.
- Requesters 0,1,3 all valid with 1-word frames from reset → grant order 0,1,3,0,… with a 2-cycle gap between frames; requester 2 never granted.
- Requester 1 streams 20 words with no last, MAX_BURST=16 → exactly 16 handshakes, burst_overrun pulses once, requester 1 re-granted only after other pending requesters.
- Requester 0 sends 1 word then drops valid for 40 cycles, IDLE_TIMEOUT=32 → idle_timeout pulses 33 cycles after valid drops, busy=0, requester 3 (pending) then granted.
- tx_ready toggles 1010… during a 4-word frame from requester 2 → each word held stable until accepted, req_ready[2] mirrors tx_ready, no other req_ready high.
- rst asserted for 1 cycle mid-frame (after word 2 of 5) → next cycle tx_valid=0, busy=0, all counters 0; next arbitration starts from requester 0.
